// File: rtl/obi_mem_responder.sv
// OBI slave endpoint backed by a word-addressed register-file memory, with a fixed
// grant-to-rvalid latency and a bounded number of outstanding transactions.
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_mem_responder
  import obi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned NUM_WORDS       = 256,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  slave_req_i,
  output obi_resp_t slave_resp_o,
  input  logic      stall_i,
  output logic      busy_o
);

  localparam int unsigned      IDX_W    = $clog2(NUM_WORDS);
  localparam int unsigned      CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0]      SPAN     = 32'(NUM_WORDS * 4);
  localparam logic [31:0]      OOR_DATA = 32'hBADC_AB1E;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]             mem [NUM_WORDS];
  logic [31:0]             off;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic                    gnt;
  logic                    rsp_fire;
  logic [31:0]             rsp_data;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [31:0]             pipe_data [READ_LATENCY];

  always_comb begin
    off      = slave_req_i.addr - BASE_ADDR;
    in_range = off < SPAN;
    idx      = off[2 +: IDX_W];
    rsp_fire = pipe_valid[READ_LATENCY-1];
    // A response leaving this cycle frees a slot, so a full counter can still grant.
    gnt      = slave_req_i.req & ~stall_i & ((cnt < CNT_MAX) | rsp_fire);
    if (slave_req_i.we) begin
      rsp_data = '0;
    end else if (in_range) begin
      rsp_data = mem[idx];
    end else begin
      rsp_data = OOR_DATA;
    end
    cnt_next = cnt + CNT_W'(gnt) - CNT_W'(rsp_fire);
  end

  always_comb begin
    slave_resp_o        = '0;
    slave_resp_o.gnt    = gnt;
    slave_resp_o.rvalid = pipe_valid[READ_LATENCY-1];
    slave_resp_o.rdata  = pipe_data[READ_LATENCY-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned w = 0; w < NUM_WORDS; w++) begin
        mem[w] <= '0;
      end
    end else if (gnt && slave_req_i.we && in_range) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (slave_req_i.be[k]) begin
          mem[idx][8*k +: 8] <= slave_req_i.wdata[8*k +: 8];
        end
      end
    end
  end

  // Data moves only with a valid entry, so the last stage holds rdata between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      for (int unsigned s = 0; s < READ_LATENCY; s++) begin
        pipe_data[s] <= '0;
      end
    end else begin
      pipe_valid[0] <= gnt;
      if (gnt) begin
        pipe_data[0] <= rsp_data;
      end
      for (int unsigned s = 1; s < READ_LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        if (pipe_valid[s-1]) begin
          pipe_data[s] <= pipe_data[s-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt    <= '0;
      busy_o <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      busy_o <= (cnt_next != '0);
    end
  end

  a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt <= CNT_MAX);
  a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) rsp_fire |-> (cnt != '0));

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed and randomized checks of obi_mem_responder against a queue-based
// transaction model (memory array plus list of responses with due cycles).
module tb_obi_mem_responder;
  import obi_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned NW   = 16;
  localparam int unsigned L    = 3;
  localparam int unsigned M    = 2;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } pend_t;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      stall = 1'b0;
  logic      busy;
  obi_req_t  sreq = '0;
  obi_resp_t sresp;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic [31:0] mmem [NW];
  pend_t       pend [$];
  logic [31:0] last_rdata = '0;

  obi_mem_responder #(
    .BASE_ADDR(BASE),
    .NUM_WORDS(NW),
    .READ_LATENCY(L),
    .MAX_OUTSTANDING(M)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .slave_req_i(sreq),
    .slave_resp_o(sresp),
    .stall_i(stall),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NW; i++) mmem[i] = '0;
    pend.delete();
    last_rdata = '0;
  endfunction

  function automatic void model_accept(input logic w, input logic [3:0] b,
                                       input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    logic [31:0] rd;
    int unsigned ix;
    bit inr;
    off = a - BASE;
    inr = off < 32'(NW * 4);
    ix  = (off / 4) % NW;
    if (w) begin
      if (inr)
        for (int k = 0; k < 4; k++)
          if (b[k]) mmem[ix][8*k +: 8] = d[8*k +: 8];
      rd = '0;
    end else begin
      rd = inr ? mmem[ix] : 32'hBADC_AB1E;
    end
    pend.push_back('{due: cyc + L, data: rd});
  endfunction

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic step(input logic r, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d, input logic s,
                      output logic g_obs);
    logic fire, exp_gnt;
    sreq.req = r; sreq.we = w; sreq.be = b; sreq.addr = a; sreq.wdata = d;
    stall = s;
    @(negedge clk);
    fire    = (pend.size() != 0) && (pend[0].due == cyc);
    exp_gnt = r && !s && ((pend.size() < M) || fire);
    if (fire) last_rdata = pend[0].data;
    check("gnt", 32'(sresp.gnt), 32'(exp_gnt));
    check("rvalid", 32'(sresp.rvalid), 32'(fire));
    check("rdata", sresp.rdata, last_rdata);
    check("busy", 32'(busy), 32'(pend.size() != 0));
    g_obs = sresp.gnt;
    @(posedge clk);
    if (fire) void'(pend.pop_front());
    if (exp_gnt) model_accept(w, b, a, d);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    logic g;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, g);
  endtask

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d);
    logic g;
    g = 1'b0;
    for (int n = 0; n < 16 && !g; n++) step(1'b1, w, b, a, d, 1'b0, g);
    check("issue_granted", 32'(g), 32'd1);
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    check("rst_rvalid_async", 32'(sresp.rvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", sresp.rdata, 32'd0);
    model_clear();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic g, held;
    logic hr, hw;
    logic [3:0] hb;
    logic [31:0] ha, hd;
    int unsigned start;

    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Write then read the same word.
    issue(1'b1, 4'hF, BASE + 32'h10, 32'hCAFE_F00D);
    issue(1'b0, 4'hF, BASE + 32'h10, '0);
    idle(L + 1);
    check("wr_rd_data", sresp.rdata, 32'hCAFE_F00D);

    // Byte enables.
    issue(1'b1, 4'hF, BASE + 32'h14, 32'h1122_3344);
    issue(1'b1, 4'b0101, BASE + 32'h14, 32'hAABB_CCDD);
    issue(1'b0, 4'hF, BASE + 32'h16, '0);
    idle(L + 1);
    check("be_data", sresp.rdata, 32'h11BB_33DD);

    // Back-to-back reads of words 0..3 with MAX_OUTSTANDING < READ_LATENCY.
    idle(L + 1);
    start = cyc;
    for (int w = 0; w < 4; w++) issue(1'b0, 4'hF, BASE + 32'(w * 4), '0);
    check("b2b_cycles", cyc - start, 32'd5);
    idle(L + 1);

    // Stall while an earlier read is in flight.
    issue(1'b0, 4'hF, BASE + 32'h10, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 4'hF, BASE + 32'h14, '0, 1'b1, g);
      check("stall_gnt", 32'(g), 32'd0);
    end
    start = cyc;
    issue(1'b0, 4'hF, BASE + 32'h14, '0);
    check("stall_release_cycles", cyc - start, 32'd1);
    idle(L + 1);

    // Out of range: read returns the marker, write is dropped.
    issue(1'b1, 4'hF, BASE, 32'h5A5A_0001);
    issue(1'b0, 4'hF, BASE + 32'(NW * 4), '0);
    idle(L + 1);
    check("oor_read", sresp.rdata, 32'hBADC_AB1E);
    issue(1'b1, 4'hF, BASE + 32'(NW * 4), 32'hDEAD_BEEF);
    issue(1'b0, 4'hF, BASE, '0);
    idle(L + 1);
    check("oor_write_dropped", sresp.rdata, 32'h5A5A_0001);

    // Reset while one response is due and another is in flight.
    issue(1'b0, 4'hF, BASE + 32'h10, '0);
    issue(1'b0, 4'hF, BASE + 32'h14, '0);
    idle(1);
    check("pre_rst_rvalid", 32'(sresp.rvalid), 32'd1);
    reset_mid();
    step(1'b1, 1'b0, 4'hF, BASE + 32'h10, '0, 1'b0, g);
    check("first_gnt_after_rst", 32'(g), 32'd1);
    idle(L + 1);

    // Randomized traffic; an ungranted request is held stable.
    held = 1'b0;
    hr = 1'b0; hw = 1'b0; hb = '0; ha = '0; hd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        hr = ($urandom_range(0, 9) < 7);
        hw = 1'($urandom_range(0, 1));
        hb = 4'($urandom);
        hd = $urandom;
        case ($urandom_range(0, 9))
          0:       ha = BASE + 32'(NW * 4) + 32'($urandom_range(0, 255));
          1:       ha = BASE - 32'h4;
          default: ha = BASE + 32'($urandom_range(0, NW - 1) * 4) + 32'($urandom_range(0, 3));
        endcase
      end
      step(hr, hw, hb, ha, hd, ($urandom_range(0, 4) == 0), g);
      held = hr && !g;
    end
    idle(L + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
